// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter and its wait timer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_WAIT,
        LS_WAIT
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } arb_owner_t;

    localparam logic [3:0] FETCH_MASK = 4'b1111;

endpackage

// File: rtl/mem_arb_timer.sv
// Wait-state counter for the memory port arbiter; flags an abort when a
// transaction has waited TimeoutCycles cycles without a completion strobe.
module mem_arb_timer #(
    parameter int TimeoutCycles = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic busy_i,
    input  logic data_valid_i,
    output logic expire_o
);

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Counter is zero whenever idle, so every new transaction starts from 0.
    always_comb begin
        expire_o = busy_i && !data_valid_i && (count_q == Limit);
        count_d  = '0;
        if (busy_i && !data_valid_i && !expire_o) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; load/store has fixed priority.
// Optional wait-state abort is compiled in with MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [DataWidth-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic                 if_stall,
    output logic [DataWidth-1:0] if_rdata,
    input  logic                 ls_req,
    input  logic                 ls_we,
    input  logic [DataWidth-1:0] ls_addr,
    input  logic [DataWidth-1:0] ls_wdata,
    input  logic [3:0]           ls_mask,
    output logic                 ls_gnt,
    output logic                 ls_rvalid,
    output logic                 ls_stall,
    output logic [DataWidth-1:0] ls_rdata,
    output logic                 mem_request,
    output logic                 mem_we_re,
    output logic [DataWidth-1:0] mem_addr,
    output logic [DataWidth-1:0] mem_wdata,
    output logic [3:0]           mem_mask,
    input  logic                 mem_data_valid,
    input  logic [DataWidth-1:0] mem_rdata,
    output logic                 timeout_err
);

    arb_state_t           state_q, state_d;
    logic [DataWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [3:0]           mask_q, mask_d;
    logic                 we_q, we_d;

    logic       busy;
    logic       done;
    logic       expire;
    arb_owner_t owner;

    assign busy  = (state_q != IDLE);
    assign owner = (state_q == LS_WAIT) ? OWN_LS : OWN_IF;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timer #(
        .TimeoutCycles(TimeoutCycles)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .busy_i      (busy),
        .data_valid_i(mem_data_valid),
        .expire_o    (expire)
    );
`else
    assign expire = 1'b0;
`endif

    assign done        = busy && (mem_data_valid || expire);
    assign timeout_err = expire;

    assign if_rvalid = done && (owner == OWN_IF);
    assign ls_rvalid = done && (owner == OWN_LS);
    assign if_stall  = if_req && !if_rvalid;
    assign ls_stall  = ls_req && !ls_rvalid;
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

    assign mem_request = busy;
    assign mem_we_re   = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_mask    = mask_q;

    // Acceptance only happens in IDLE, which keeps transactions at least two cycles apart.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        we_d    = we_q;
        if_gnt  = 1'b0;
        ls_gnt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ls_req) begin
                    ls_gnt  = 1'b1;
                    state_d = LS_WAIT;
                    addr_d  = ls_addr;
                    wdata_d = ls_wdata;
                    mask_d  = ls_mask;
                    we_d    = ls_we;
                end else if (if_req) begin
                    if_gnt  = 1'b1;
                    state_d = IF_WAIT;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    mask_d  = FETCH_MASK;
                    we_d    = 1'b0;
                end
            end
            IF_WAIT, LS_WAIT: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single data/instruction memory port between the fetch stage and the memory stage's load/store path. Holds the accepted transaction on the memory bus until the memory returns `data_valid`, then routes the response back to the owner and stalls the losing requester. Sits between the fetch and memory stages and the shared memory/wrapper.

## Interface
- `DataWidth`, 32, data and address width
- `TimeoutCycles`, 16, wait-state limit before abort; used only with the timeout feature enabled
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `if_req` in 1: fetch requests a read
- `if_addr` in DataWidth: fetch address
- `if_gnt` out 1: fetch request accepted this cycle
- `if_rvalid` out 1: fetch data valid, one-cycle pulse
- `if_stall` out 1: fetch must hold its request
- `ls_req` in 1: load or store request from the memory stage
- `ls_we` in 1: 1 = store, 0 = load
- `ls_addr` in DataWidth: load/store address
- `ls_wdata` in DataWidth: store data, already aligned by the wrapper
- `ls_mask` in 4: byte-enable mask
- `ls_gnt` out 1: load/store request accepted this cycle
- `ls_rvalid` out 1: load data valid or store acknowledged, one-cycle pulse
- `ls_stall` out 1: memory stage must hold its request
- `mem_request` out 1: bus request, held for the whole transaction
- `mem_we_re` out 1: 1 = write
- `mem_addr` out DataWidth: latched address
- `mem_wdata` out DataWidth: latched store data
- `mem_mask` out 4: latched mask; 4'b1111 for fetch
- `mem_data_valid` in 1: memory completion strobe
- `mem_rdata` in DataWidth: memory read data; passed combinationally to both `*_rdata` consumers
- `timeout_err` out 1: abort pulse; tied to 0 when the timeout feature is compiled out

## Operation
- States are IDLE, IF_WAIT and LS_WAIT.
- **In IDLE:**
  - If `ls_req` is high: assert `ls_gnt`, latch ls address/data/mask/we, and go to LS_WAIT.
  - Otherwise, if `if_req` is high: assert `if_gnt`, latch `if_addr` with mask 4'b1111 and we=0, and go to IF_WAIT.
  - Priority is fixed: load/store wins over fetch.
- **In the WAIT states:**
  - `mem_request` is 1; `mem_*` outputs come from the latched registers and never change mid-transaction.
  - When `mem_data_valid` is high, pulse the owner's `*_rvalid` in that same cycle and return to IDLE.
- **Stall outputs:**
  - `ls_stall` is high whenever `ls_req` is high and `ls_rvalid` is low.
  - `if_stall` follows the same rule using `if_req` and `if_rvalid`.
- **Stray strobes:** `mem_data_valid` in IDLE is ignored and produces no pulse.
- **Requester behaviour:** a requester holds its `req` and operands until its `rvalid`. Dropping `req` after grant does not cancel the transaction; the transaction still completes.

## Timing
- **Reset values:** state IDLE; all outputs 0; latched registers 0.
- **Latency:** request accepted (`gnt`) in cycle N → `mem_request` high from N+1 → `rvalid` in the first cycle ≥ N+1 with `mem_data_valid`. The FSM is back in IDLE the cycle after that.
- **Minimum spacing:** one transaction every 2 cycles. There is no acceptance in the completion cycle.
- **Simultaneous `if_req` and `ls_req` in IDLE:** ls granted; fetch stays stalled and is granted on the next IDLE cycle if still requesting.
- **Reset asserted mid-transaction:** the transaction is abandoned, `mem_request` drops immediately (async), and no `rvalid` is produced.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A wait counter clears on entry to a WAIT state and increments each WAIT cycle without `mem_data_valid`.
  - When the counter reaches `TimeoutCycles`-1, the arbiter pulses `timeout_err` and the owner's `rvalid` (rdata undefined) for one cycle, then returns to IDLE.
  - `mem_data_valid` arriving in the same cycle takes precedence: normal completion, no error.
- Not defined: no counter; a WAIT state persists indefinitely; `timeout_err` is constant 0.

## Structure
- Shared package `mem_arb_pkg` holds:
  - `arb_state_t` enum (IDLE, IF_WAIT, LS_WAIT)
  - `arb_owner_t` enum (OWN_IF, OWN_LS)
  - `FETCH_MASK` constant 4'b1111
- Sub-module `mem_arb_timer` holds the wait counter and compare, instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- **Fetch read:** `if_req`=1, `if_addr`=0x100; memory answers `mem_data_valid` 2 cycles after `mem_request` with 0xDEADBEEF → `if_gnt` in cycle 0, `mem_mask`=4'b1111, `if_rvalid` with rdata 0xDEADBEEF in cycle 3, `if_stall` high in cycles 0–2.
- **Store:** `ls_req`=1, `ls_we`=1, addr 0x204, wdata 0x000000AB, mask 4'b0001 → `mem_we_re`=1 and latched values held until `mem_data_valid`; `ls_rvalid` pulses once.
- **Contention:** `if_req`=`ls_req`=1 in IDLE → ls served first; fetch granted in the IDLE cycle after `ls_rvalid`; `if_stall` stays high throughout.
- **Async reset:** `rst`=0 while in LS_WAIT → `mem_request`=0 immediately; a later stray `mem_data_valid` produces no `rvalid`.
- **Timeout, `MEM_ARB_TIMEOUT_EN` with `TimeoutCycles`=4:**
  - No `mem_data_valid` → `timeout_err` and `ls_rvalid` pulse in the 4th WAIT cycle, then IDLE.
  - `mem_data_valid` in that same 4th cycle → no `timeout_err`.
